operand_arbiter_pipe: RTL and testbench

Parametrised, registered successor to the EX-stage operand arbitrator. It resolves RS1/RS2 from the regfile or from NUM_FWD forwarding sources, with the youngest source winning. It detects not-yet-ready producers (load-use) and stalls, then selects operand A/B and drives a registered valid/ready output stage into the ALU/LSU. It sits between the ID/EX register and the ALU/LSU.

---
 rtl/operand_arbiter_pipe.sv | 167 ++++++++++++++++
 tb/tb_operand_arbiter_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/operand_arbiter_pipe.sv
// EX-stage operand arbiter: forwarding resolution, load-use stall, registered valid/ready output.
// Optional perf counters (stall cycles, forwarded packets) under OPERAND_ARB_PERF_CNT_EN.
module operand_arbiter_fwd_sel #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      use_i,
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD-1:0]        fwd_pending_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]           data_o,
  output logic                      hit_o,
  output logic                      pend_o
);
  // Walk oldest to youngest so the youngest (lowest k) match overrides.
  always_comb begin
    data_o = (addr_i == '0) ? '0 : rf_data_i;
    hit_o  = 1'b0;
    pend_o = 1'b0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (use_i && fwd_valid_i[k] && (addr_i != '0) &&
          (fwd_rd_addr_i[k*REG_AW +: REG_AW] == addr_i)) begin
        data_o = fwd_data_i[k*XLEN +: XLEN];
        hit_o  = 1'b1;
        pend_o = fwd_pending_i[k];
      end
    end
  end
endmodule

module operand_arbiter_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [REG_AW-1:0]         i_rs1_addr,
  input  logic [REG_AW-1:0]         i_rs2_addr,
  input  logic                      i_use_rs1,
  input  logic                      i_use_rs2,
  input  logic                      i_op_a_use_pc,
  input  logic                      i_op_b_use_imm,
  input  logic [XLEN-1:0]           i_pc,
  input  logic [XLEN-1:0]           i_imm,
  input  logic [XLEN-1:0]           i_rs1_data,
  input  logic [XLEN-1:0]           i_rs2_data,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD-1:0]        i_fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [XLEN-1:0]           o_operand_a,
  output logic [XLEN-1:0]           o_operand_b,
  output logic [XLEN-1:0]           o_rs1_data,
  output logic [XLEN-1:0]           o_rs2_data,
`ifdef OPERAND_ARB_PERF_CNT_EN
  output logic [31:0]               o_stall_cycles,
  output logic [31:0]               o_fwd_count,
`endif
  output logic                      o_hazard
);
  logic [1:0]             rs_use, rs_hit, rs_pend;
  logic [1:0][REG_AW-1:0] rs_addr;
  logic [1:0][XLEN-1:0]   rs_rf, rs_fwd;

  assign rs_use  = {i_use_rs2, i_use_rs1};
  assign rs_addr = {i_rs2_addr, i_rs1_addr};
  assign rs_rf   = {i_rs2_data, i_rs1_data};

  for (genvar s = 0; s < 2; s++) begin : g_rs
    operand_arbiter_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_sel (
      .use_i        (rs_use[s]),
      .addr_i       (rs_addr[s]),
      .rf_data_i    (rs_rf[s]),
      .fwd_valid_i  (i_fwd_valid),
      .fwd_pending_i(i_fwd_pending),
      .fwd_rd_addr_i(i_fwd_rd_addr),
      .fwd_data_i   (i_fwd_data),
      .data_o       (rs_fwd[s]),
      .hit_o        (rs_hit[s]),
      .pend_o       (rs_pend[s])
    );
  end

  logic            load;
  logic [XLEN-1:0] op_a_d, op_b_d;
  logic            valid_q;
  logic [XLEN-1:0] op_a_q, op_b_q, rs1_q, rs2_q;

  assign o_hazard = i_valid & |(rs_hit & rs_pend);
  assign o_ready  = ~o_hazard & (~valid_q | i_ready) & ~i_flush;
  assign load     = i_valid & o_ready;

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    if (i_op_a_use_pc)    op_a_d = i_pc;
    else if (i_use_rs1)   op_a_d = rs_fwd[0];
    if (i_op_b_use_imm)   op_b_d = i_imm;
    else if (i_use_rs2)   op_b_d = rs_fwd[1];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      if (i_flush)      valid_q <= 1'b0;
      else if (load)    valid_q <= 1'b1;
      else if (i_ready) valid_q <= 1'b0;
      if (load) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
        rs1_q  <= rs_fwd[0];
        rs2_q  <= rs_fwd[1];
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_operand_a = op_a_q;
  assign o_operand_b = op_b_q;
  assign o_rs1_data  = rs1_q;
  assign o_rs2_data  = rs2_q;

`ifdef OPERAND_ARB_PERF_CNT_EN
  typedef enum logic {RUN, STALL} state_e;
  state_e      state_q, state_d;
  logic [31:0] stall_q, fwdc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_valid && o_hazard)  state_d = STALL;
      STALL:   if (!o_hazard || i_flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      stall_q <= '0;
      fwdc_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == STALL && i_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (load && |rs_hit && fwdc_q != '1)              fwdc_q  <= fwdc_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_fwd_count    = fwdc_q;
`endif
endmodule

// File: tb/tb_operand_arbiter_pipe.sv
// Directed bench for operand_arbiter_pipe: forwarding priority, x0, load-use, backpressure, flush, reset.
module tb_operand_arbiter_pipe;
  localparam int XLEN = 32, NUM_FWD = 2, REG_AW = 5;

  logic i_clk = 1'b0, i_reset, i_valid, o_ready;
  logic [REG_AW-1:0] i_rs1_addr, i_rs2_addr;
  logic i_use_rs1, i_use_rs2, i_op_a_use_pc, i_op_b_use_imm;
  logic [XLEN-1:0] i_pc, i_imm, i_rs1_data, i_rs2_data;
  logic [NUM_FWD-1:0] i_fwd_valid, i_fwd_pending;
  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd_addr;
  logic [NUM_FWD*XLEN-1:0] i_fwd_data;
  logic i_flush, o_valid, i_ready, o_hazard;
  logic [XLEN-1:0] o_operand_a, o_operand_b, o_rs1_data, o_rs2_data;
`ifdef OPERAND_ARB_PERF_CNT_EN
  logic [31:0] o_stall_cycles, o_fwd_count;
`endif

  int checks = 0, errors = 0;

  always #5 i_clk = ~i_clk;

  operand_arbiter_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_use_rs1(i_use_rs1), .i_use_rs2(i_use_rs2),
    .i_op_a_use_pc(i_op_a_use_pc), .i_op_b_use_imm(i_op_b_use_imm),
    .i_pc(i_pc), .i_imm(i_imm), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_fwd_valid(i_fwd_valid), .i_fwd_pending(i_fwd_pending),
    .i_fwd_rd_addr(i_fwd_rd_addr), .i_fwd_data(i_fwd_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_operand_a(o_operand_a), .o_operand_b(o_operand_b),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
`ifdef OPERAND_ARB_PERF_CNT_EN
    .o_stall_cycles(o_stall_cycles), .o_fwd_count(o_fwd_count),
`endif
    .o_hazard(o_hazard)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs settle 1 ns after the edge.
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_use_rs1 = 0; i_use_rs2 = 0;
    i_op_a_use_pc = 0; i_op_b_use_imm = 0; i_pc = 0; i_imm = 0;
    i_rs1_data = 0; i_rs2_data = 0; i_fwd_valid = 0; i_fwd_pending = 0;
    i_fwd_rd_addr = 0; i_fwd_data = 0; i_flush = 0; i_ready = 1;
  endtask

  task automatic alu(input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] d1, input logic [31:0] d2);
    idle_inputs();
    i_valid = 1; i_use_rs1 = 1; i_use_rs2 = 1;
    i_rs1_addr = r1; i_rs2_addr = r2; i_rs1_data = d1; i_rs2_data = d2;
  endtask

  initial begin
    idle_inputs();
    i_reset = 1;
    #3;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_a", o_operand_a, 32'd0);
    chk("rst_rs2", o_rs2_data, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    tick();
    i_reset = 0;

    // Plain ALU op from the regfile
    alu(5'd3, 5'd4, 32'h10, 32'h20);
    #1;
    chk("plain_ready", {31'd0, o_ready}, 32'd1);
    chk("plain_haz", {31'd0, o_hazard}, 32'd0);
    tick();
    chk("plain_valid", {31'd0, o_valid}, 32'd1);
    chk("plain_a", o_operand_a, 32'h10);
    chk("plain_b", o_operand_b, 32'h20);

    // Both sources match rd=5: youngest wins, then the older one
    idle_inputs();
    i_valid = 1; i_use_rs1 = 1; i_rs1_addr = 5; i_rs1_data = 32'h5555;
    i_op_b_use_imm = 1; i_imm = 32'h7;
    i_fwd_valid = 2'b11; i_fwd_rd_addr = {5'd5, 5'd5};
    i_fwd_data = {32'hBBBB, 32'hAAAA};
    tick();
    chk("dual_a", o_operand_a, 32'hAAAA);
    chk("dual_b_imm", o_operand_b, 32'h7);
    i_fwd_valid = 2'b10;
    tick();
    chk("older_a", o_operand_a, 32'hBBBB);
    chk("older_rs1", o_rs1_data, 32'hBBBB);

    // x0 never forwards and reads zero
    idle_inputs();
    i_valid = 1; i_use_rs1 = 1; i_rs1_addr = 0; i_rs1_data = 32'h55;
    i_fwd_valid = 2'b01; i_fwd_rd_addr = {5'd0, 5'd0}; i_fwd_data = {32'h0, 32'h1234};
    tick();
    chk("x0_a", o_operand_a, 32'h0);
    chk("x0_rs1", o_rs1_data, 32'h0);

    // PC on A, no rs2 use -> B is zero
    idle_inputs();
    i_valid = 1; i_op_a_use_pc = 1; i_pc = 32'h400; i_rs2_addr = 6; i_rs2_data = 32'h66;
    tick();
    chk("pc_a", o_operand_a, 32'h400);
    chk("nors2_b", o_operand_b, 32'h0);

    // Load-use on rs2: youngest pending, older valid copy must not bypass it
    idle_inputs();
    i_valid = 1; i_use_rs2 = 1; i_rs2_addr = 7; i_rs2_data = 32'h1;
    i_fwd_valid = 2'b11; i_fwd_pending = 2'b01;
    i_fwd_rd_addr = {5'd7, 5'd7}; i_fwd_data = {32'h77, 32'h0};
    #1;
    chk("lu_haz", {31'd0, o_hazard}, 32'd1);
    chk("lu_ready", {31'd0, o_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, o_valid}, 32'd0);
    i_fwd_pending = 2'b00; i_fwd_data = {32'h77, 32'h99};
    #1;
    chk("lu_clear", {31'd0, o_ready}, 32'd1);
    tick();
    chk("lu_valid", {31'd0, o_valid}, 32'd1);
    chk("lu_b", o_operand_b, 32'h99);
`ifdef OPERAND_ARB_PERF_CNT_EN
    chk("stall_cnt", o_stall_cycles, 32'd1);
    chk("fwd_cnt", o_fwd_count, 32'd3);
`endif

    // Backpressure holds outputs for 3 cycles, then flush drops a same-cycle input
    alu(5'd3, 5'd4, 32'h31, 32'h32);
    i_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_b", o_operand_b, 32'h99);
    end
    i_flush = 1;
    #1;
    chk("fl_ready", {31'd0, o_ready}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    i_flush = 0; i_valid = 0; i_ready = 1;
    tick();
    chk("fl_dropped", {31'd0, o_valid}, 32'd0);
    chk("fl_hold_a", o_operand_a, 32'h0);

    // Reset asserted mid-stall clears the output asynchronously
    alu(5'd3, 5'd4, 32'h44, 32'h45);
    tick();
    chk("pre_a", o_operand_a, 32'h44);
    alu(5'd9, 5'd4, 32'h1, 32'h2);
    i_ready = 0;
    i_fwd_valid = 2'b01; i_fwd_pending = 2'b01; i_fwd_rd_addr = {5'd0, 5'd9};
    tick();
    chk("ms_haz", {31'd0, o_hazard}, 32'd1);
    chk("ms_held", {31'd0, o_valid}, 32'd1);
    #2 i_reset = 1;
    #1;
    chk("ms_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("ms_rst_a", o_operand_a, 32'h0);
    chk("ms_rst_b", o_operand_b, 32'h0);
`ifdef OPERAND_ARB_PERF_CNT_EN
    chk("ms_rst_stall", o_stall_cycles, 32'd0);
`endif
    i_reset = 0;
    alu(5'd3, 5'd4, 32'h66, 32'h67);
    tick();
    chk("post_valid", {31'd0, o_valid}, 32'd1);
    chk("post_a", o_operand_a, 32'h66);
    chk("post_b", o_operand_b, 32'h67);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
